// File: rtl/data_compact_pkg.sv
// Shared defaults and helpers for the data_compact group compactor.
package data_compact_pkg;

    localparam int GW_DEF = 8;
    localparam int GN_DEF = 4;
    localparam int SEL_W  = (GN_DEF > 1) ? $clog2(GN_DEF) : 1;

    // One lane's source-group index for the default geometry
    typedef logic [SEL_W-1:0] lane_sel_t;

    function automatic int popcount(input logic [31:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic logic [31:0] thermo(input int n);
        logic [31:0] t;
        t = '0;
        for (int i = 0; i < 32; i++) if (i < n) t[i] = 1'b1;
        return t;
    endfunction

endpackage

// File: rtl/data_compact_sel.sv
// Config holding register plus the registered lane-select table and enabled-lane count.
module data_compact_sel
    import data_compact_pkg::*;
#(
    parameter  int GN = GN_DEF,
    localparam int SW = (GN > 1) ? $clog2(GN) : 1,
    localparam int CW = $clog2(GN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [GN-1:0]        disabled_groups,
    input  logic                 idle,
    output logic [GN-1:0][SW-1:0] sel,
    output logic [CW-1:0]        n_en,
    output logic                 cfg_busy
);

    logic [GN-1:0]         cfg;
    logic [GN-1:0]         pend;
    logic [GN-1:0]         cfg_eff;
    logic [GN-1:0]         en;
    logic [GN-1:0][SW-1:0] sel_nxt;
    logic [SW-1:0]         lane;
    logic                  cfg_load;

    assign cfg_load = idle && !cfg_busy && (pend != cfg);

    // All groups disabled degenerates to pass-through
    always_comb begin
        cfg_eff = (&cfg) ? '0 : cfg;
        en      = ~cfg_eff;
        sel_nxt = '0;
        lane    = '0;
        for (int g = 0; g < GN; g++) begin
            if (en[g]) begin
                sel_nxt[lane] = SW'(g);
                lane          = lane + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg      <= '0;
            pend     <= '0;
            cfg_busy <= 1'b0;
            n_en     <= CW'(GN);
            for (int k = 0; k < GN; k++) sel[k] <= SW'(k);
        end else begin
            pend     <= disabled_groups;
            cfg_busy <= cfg_load;
            sel      <= sel_nxt;
            n_en     <= CW'(popcount(32'(en)));
            if (cfg_load) cfg <= pend;
        end
    end

endmodule

// File: rtl/data_compact.sv
// Group compactor: drops disabled GW-bit groups and packs the rest from lane 0.
// Define DATA_COMPACT_PACK_EN to pack several compacted samples per output word.
module data_compact
    import data_compact_pkg::*;
#(
    parameter  int GW = GW_DEF,
    parameter  int GN = GN_DEF,
    parameter  int KW = GN,
    localparam int DW = GW * GN
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [GN-1:0] disabled_groups,
    input  logic          flush,
    output logic          sti_tready,
    input  logic          sti_tvalid,
    input  logic [DW-1:0] sti_tdata,
    input  logic          sto_tready,
    output logic          sto_tvalid,
    output logic [DW-1:0] sto_tdata,
    output logic [KW-1:0] sto_tkeep
);

    localparam int SW = (GN > 1) ? $clog2(GN) : 1;
    localparam int CW = $clog2(GN + 1);

    logic [GN-1:0][SW-1:0] sel;
    logic [CW-1:0]         n_en;
    logic                  cfg_busy;
    logic [CW-1:0]         cnt;
    logic                  idle;
    logic                  take;
    logic [DW-1:0]         cmp;

    assign idle       = !sto_tvalid && (cnt == '0) && !sti_tvalid;
    assign sti_tready = (!sto_tvalid || sto_tready) && !cfg_busy;
    assign take       = sti_tvalid && sti_tready;

    data_compact_sel #(.GN(GN)) u_sel (
        .clk             (clk),
        .rst             (rst),
        .disabled_groups (disabled_groups),
        .idle            (idle),
        .sel             (sel),
        .n_en            (n_en),
        .cfg_busy        (cfg_busy)
    );

    always_comb begin
        cmp = '0;
        for (int k = 0; k < GN; k++) begin
            if (CW'(k) < n_en) cmp[k*GW +: GW] = sti_tdata[sel[k]*GW +: GW];
        end
    end

`ifdef DATA_COMPACT_PACK_EN

    logic [DW-1:0] acc;
    logic [DW-1:0] word;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] s_lim;
    logic          flush_pend;
    logic          flush_req;
    logic          out_free;
    logic          emit;

    assign s_lim     = CW'(GN / int'(n_en));
    assign out_free  = !sto_tvalid || sto_tready;
    assign flush_req = flush || flush_pend;

    always_comb begin
        word    = acc;
        cnt_nxt = cnt;
        if (take) begin
            word    = acc | (cmp << (int'(cnt) * int'(n_en) * GW));
            cnt_nxt = cnt + CW'(1);
        end
        emit = (take && ((cnt_nxt == s_lim) || flush_req)) ||
               (!take && flush_req && (cnt != '0) && out_free);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sto_tvalid <= 1'b0;
            sto_tdata  <= '0;
            sto_tkeep  <= '0;
            acc        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else if (emit) begin
            sto_tvalid <= 1'b1;
            sto_tdata  <= word;
            sto_tkeep  <= KW'(thermo(int'(cnt_nxt) * int'(n_en)));
            acc        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (sto_tready) sto_tvalid <= 1'b0;
            if (take) begin
                acc <= word;
                cnt <= cnt_nxt;
            end
            // A flush arriving while the output is stalled is remembered
            if (flush && (cnt != '0)) flush_pend <= 1'b1;
        end
    end

`else

    logic unused_flush;
    assign unused_flush = flush;
    assign cnt          = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sto_tvalid <= 1'b0;
            sto_tdata  <= '0;
            sto_tkeep  <= '0;
        end else if (take) begin
            sto_tvalid <= 1'b1;
            sto_tdata  <= cmp;
            sto_tkeep  <= KW'(thermo(int'(n_en)));
        end else if (sto_tready) begin
            sto_tvalid <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_data_compact.sv
// Self-checking bench for data_compact: vector table, directed corner sequences, random scoreboard.
module tb_data_compact;

    localparam int GW = 8;
    localparam int GN = 4;
    localparam int DW = GW * GN;
`ifdef DATA_COMPACT_PACK_EN
    localparam bit PACK = 1'b1;
`else
    localparam bit PACK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [GN-1:0] disabled_groups;
    logic          flush;
    logic          sti_tready;
    logic          sti_tvalid;
    logic [DW-1:0] sti_tdata;
    logic          sto_tready;
    logic          sto_tvalid;
    logic [DW-1:0] sto_tdata;
    logic [GN-1:0] sto_tkeep;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_compact #(.GW(GW), .GN(GN), .KW(GN)) dut (
        .clk             (clk),
        .rst             (rst),
        .disabled_groups (disabled_groups),
        .flush           (flush),
        .sti_tready      (sti_tready),
        .sti_tvalid      (sti_tvalid),
        .sti_tdata       (sti_tdata),
        .sto_tready      (sto_tready),
        .sto_tvalid      (sto_tvalid),
        .sto_tdata       (sto_tdata),
        .sto_tkeep       (sto_tkeep)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [GN-1:0] keep;
    } word_t;

    typedef struct {
        logic [GN-1:0] cfg;
        logic [DW-1:0] din;
        logic [DW-1:0] dout;
        logic [GN-1:0] keep;
    } vec_t;

    // Reference model: lanes are collected into a queue and emitted as a word
    logic [GN-1:0] model_cfg;
    logic [GW-1:0] part[$];
    int            part_samples = 0;
    word_t         expq[$];
    word_t         mon_w;
    bit            sb_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int n_enabled(input logic [GN-1:0] c);
        int n;
        n = 0;
        for (int i = 0; i < GN; i++) if (!c[i]) n++;
        return (n == 0) ? GN : n;
    endfunction

    function automatic void model_emit();
        word_t w;
        w = '0;
        for (int i = 0; i < part.size(); i++) begin
            w.data[i*GW +: GW] = part[i];
            w.keep[i]          = 1'b1;
        end
        expq.push_back(w);
        part.delete();
        part_samples = 0;
    endfunction

    function automatic void model_accept(input logic [DW-1:0] d);
        int s;
        s = PACK ? (GN / n_enabled(model_cfg)) : 1;
        for (int g = 0; g < GN; g++)
            if (!model_cfg[g] || (&model_cfg)) part.push_back(d[g*GW +: GW]);
        part_samples++;
        if (part_samples == s) model_emit();
    endfunction

    always @(negedge clk) begin
        if (sb_on) begin
            if (sto_tvalid && sto_tready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got %0h expected no word", sto_tdata);
                end else begin
                    mon_w = expq.pop_front();
                    check("sb_data", 64'(sto_tdata), 64'(mon_w.data));
                    check("sb_keep", 64'(sto_tkeep), 64'(mon_w.keep));
                end
            end
            if (sti_tvalid && sti_tready) model_accept(sti_tdata);
            if (PACK && flush && (part_samples > 0)) model_emit();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [GN-1:0] c);
        sti_tvalid      = 1'b0;
        flush           = 1'b0;
        sto_tready      = 1'b1;
        disabled_groups = c;
        repeat (6) tick();
        model_cfg = c;
    endtask

    vec_t vecs[9];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;

        vecs[0] = '{4'b0000, 32'h44332211, 32'h44332211, 4'hF};
        vecs[1] = '{4'b0000, 32'h88776655, 32'h88776655, 4'hF};
        vecs[2] = '{4'b0101, 32'hDDCCBBAA, 32'h0000DDBB, 4'h3};
        vecs[3] = '{4'b0111, 32'hDDCCBBAA, 32'h000000DD, 4'h1};
        vecs[4] = '{4'b1110, 32'hDDCCBBAA, 32'h000000AA, 4'h1};
        vecs[5] = '{4'b1111, 32'h12345678, 32'h12345678, 4'hF};
        vecs[6] = '{4'b1001, 32'hDDCCBBAA, 32'h0000CCBB, 4'h3};
        vecs[7] = '{4'b0010, 32'hDDCCBBAA, 32'h00DDCCAA, 4'h7};
        vecs[8] = '{4'b1000, 32'hDDCCBBAA, 32'h00CCBBAA, 4'h7};

        rst             = 1'b1;
        disabled_groups = '0;
        flush           = 1'b0;
        sti_tvalid      = 1'b0;
        sti_tdata       = '0;
        sto_tready      = 1'b1;
        model_cfg       = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_tvalid", 64'(sto_tvalid), 64'd0);
        check("reset_tdata", 64'(sto_tdata), 64'd0);
        check("reset_tkeep", 64'(sto_tkeep), 64'd0);
        check("reset_tready", 64'(sti_tready), 64'd1);

        // Single-sample vectors; flush makes pack builds emit the lone sample too
        for (int i = 0; i < 9; i++) begin
            set_cfg(vecs[i].cfg);
            sti_tvalid = 1'b1;
            sti_tdata  = vecs[i].din;
            flush      = 1'b1;
            tick();
            sti_tvalid = 1'b0;
            flush      = 1'b0;
            check("vec_valid", 64'(sto_tvalid), 64'd1);
            check("vec_data", 64'(sto_tdata), 64'(vecs[i].dout));
            check("vec_keep", 64'(sto_tkeep), 64'(vecs[i].keep));
            tick();
        end

        // Back-to-back stream, one-cycle latency
        set_cfg(4'b0000);
        sti_tvalid = 1'b1;
        sti_tdata  = 32'h44332211;
        tick();
        check("t1_w0_data", 64'(sto_tdata), 64'h44332211);
        check("t1_w0_keep", 64'(sto_tkeep), 64'hF);
        sti_tdata = 32'h88776655;
        tick();
        check("t1_w1_valid", 64'(sto_tvalid), 64'd1);
        check("t1_w1_data", 64'(sto_tdata), 64'h88776655);
        sti_tvalid = 1'b0;
        tick();
        check("t1_idle", 64'(sto_tvalid), 64'd0);

        // Backpressure hold and release
        set_cfg(4'b0000);
        sti_tvalid = 1'b1;
        sti_tdata  = 32'hA4A3A2A1;
        tick();
        sti_tdata  = 32'hB4B3B2B1;
        sto_tready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("t3_ready_low", 64'(sti_tready), 64'd0);
            check("t3_hold_data", 64'(sto_tdata), 64'hA4A3A2A1);
            check("t3_hold_valid", 64'(sto_tvalid), 64'd1);
            tick();
        end
        sto_tready = 1'b1;
        tick();
        sti_tvalid = 1'b0;
        check("t3_next_data", 64'(sto_tdata), 64'hB4B3B2B1);
        check("t3_next_valid", 64'(sto_tvalid), 64'd1);
        tick();
        check("t3_no_dup", 64'(sto_tvalid), 64'd0);

        // Config change mid-stream waits for idle
        set_cfg(4'b0000);
        sti_tvalid      = 1'b1;
        sti_tdata       = 32'h14131211;
        disabled_groups = 4'b1110;
        tick();
        check("t4_w1_keep", 64'(sto_tkeep), 64'hF);
        check("t4_w1_data", 64'(sto_tdata), 64'h14131211);
        sti_tdata = 32'h24232221;
        tick();
        check("t4_w2_keep", 64'(sto_tkeep), 64'hF);
        sti_tdata = 32'h34333231;
        tick();
        check("t4_w3_keep", 64'(sto_tkeep), 64'hF);
        check("t4_w3_data", 64'(sto_tdata), 64'h34333231);
        sti_tvalid = 1'b0;
        low = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (!sti_tready) low++;
        end
        check("t4_ready_low_cycles", 64'(low), 64'd1);
        sti_tvalid = 1'b1;
        sti_tdata  = 32'hDDCCBBAA;
        flush      = 1'b1;
        tick();
        sti_tvalid = 1'b0;
        flush      = 1'b0;
        check("t4_after_data", 64'(sto_tdata), 64'h000000AA);
        check("t4_after_keep", 64'(sto_tkeep), 64'h1);
        model_cfg = 4'b1110;
        tick();

`ifdef DATA_COMPACT_PACK_EN
        set_cfg(4'b1110);
        for (int i = 0; i < 4; i++) begin
            sti_tvalid = 1'b1;
            sti_tdata  = {24'h5A5A5A, 8'(8'h11 * (i + 1))};
            tick();
            if (i == 2) check("t5_no_early_emit", 64'(sto_tvalid), 64'd0);
        end
        sti_tvalid = 1'b0;
        check("t5_full_valid", 64'(sto_tvalid), 64'd1);
        check("t5_full_data", 64'(sto_tdata), 64'h44332211);
        check("t5_full_keep", 64'(sto_tkeep), 64'hF);
        tick();
        for (int i = 0; i < 3; i++) begin
            sti_tvalid = 1'b1;
            sti_tdata  = {24'hA5A5A5, 8'(8'h11 * (i + 1))};
            tick();
        end
        sti_tvalid = 1'b0;
        check("t5_partial_wait", 64'(sto_tvalid), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_flush_data", 64'(sto_tdata), 64'h00332211);
        check("t5_flush_keep", 64'(sto_tkeep), 64'h7);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_empty_flush", 64'(sto_tvalid), 64'd0);
        tick();
        check("t5_empty_flush2", 64'(sto_tvalid), 64'd0);
`endif

        // All-disabled pass-through, then reset while holding a word
        set_cfg(4'b1111);
        sto_tready = 1'b0;
        sti_tvalid = 1'b1;
        sti_tdata  = 32'h12345678;
        flush      = 1'b1;
        tick();
        sti_tvalid = 1'b0;
        flush      = 1'b0;
        check("t6_pass_data", 64'(sto_tdata), 64'h12345678);
        check("t6_pass_keep", 64'(sto_tkeep), 64'hF);
        tick();
        check("t6_held_valid", 64'(sto_tvalid), 64'd1);
        rst             = 1'b1;
        disabled_groups = 4'b0000;
        tick();
        rst = 1'b0;
        check("t6_rst_valid", 64'(sto_tvalid), 64'd0);
        check("t6_rst_data", 64'(sto_tdata), 64'd0);
        check("t6_rst_keep", 64'(sto_tkeep), 64'd0);
        check("t6_rst_ready", 64'(sti_tready), 64'd1);
        model_cfg = 4'b0000;

        // Randomised traffic against the scoreboard
        sb_on = 1'b1;
        for (int e = 0; e < 5; e++) begin
            set_cfg((e == 0) ? 4'b0000 : 4'($urandom_range(0, 15)));
            for (int c = 0; c < 300; c++) begin
                sti_tvalid = ($urandom_range(0, 3) != 0);
                sti_tdata  = $urandom;
                sto_tready = ($urandom_range(0, 3) != 0);
                tick();
            end
            sti_tvalid = 1'b0;
            sto_tready = 1'b1;
            repeat (3) tick();
            if (part_samples > 0) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
            end
            repeat (3) tick();
            check("sb_drained", 64'(expq.size()), 64'd0);
            check("sb_out_idle", 64'(sto_tvalid), 64'd0);
        end
        sb_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
